// File: rtl/dct_transpose_pingpong.sv
// -----------------------------------------------------------------------------
// dct_transpose_pingpong
//
// Row-to-column transpose buffer between the row DCT and the column DCT.
// Two N x N banks work in ping-pong: one bank is filled with rows while the
// other is drained as columns, so one row in and one column out per cycle can
// be sustained. Each block carries its own transpose/pass-through mode, which
// is latched with row 0 of that block.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   in_data holds a valid row
//   in_ready   buffer can accept a row this cycle
//   in_data    row, element k at [k*W_D +: W_D]
//   mode_tr    1 = transpose, 0 = pass-through (sampled with row 0)
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts the beat
//   out_data   column c (transpose) or row c (pass-through)
//   out_first  beat 0 of a block
//   out_last   beat N-1 of a block
// -----------------------------------------------------------------------------
module dct_transpose_pingpong #(
  parameter int W_D   = 26,
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*W_D-1:0] in_data,
  input  logic             mode_tr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W_D-1:0] out_data,
  output logic             out_first,
  output logic             out_last
);

  // Bank storage: mem_q[bank][row] holds one full row. Never reset.
  logic [N*W_D-1:0] mem_q [0:1][0:N-1];

  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [LOG_N-1:0] wr_row_q;
  logic [LOG_N-1:0] rd_col_q;
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic [1:0]       mode_q;

  logic             out_valid_q;
  logic             out_first_q;
  logic             out_last_q;
  logic [N*W_D-1:0] out_data_q;

  logic             wr_en_s;
  logic             wr_last_s;
  logic             rd_en_s;
  logic             rd_last_s;
  logic [N*W_D-1:0] rd_beat_s;

  // The write bank is writable as long as it does not still hold an undrained block.
  assign in_ready  = ~full_q[wr_bank_q];
  assign wr_en_s   = in_valid & in_ready;
  assign wr_last_s = wr_en_s & (wr_row_q == LOG_N'(N - 1));

  // Output register is free when empty or when its beat is being taken.
  assign rd_en_s   = full_q[rd_bank_q] & (~out_valid_q | out_ready);
  assign rd_last_s = rd_en_s & (rd_col_q == LOG_N'(N - 1));

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  // Select the next output beat: column rd_col (transpose) or row rd_col.
  always_comb begin
    rd_beat_s = '0;
    for (int k = 0; k < N; k++) begin
      if (mode_q[rd_bank_q]) begin
        rd_beat_s[k*W_D +: W_D] = mem_q[rd_bank_q][k][int'(rd_col_q)*W_D +: W_D];
      end else begin
        rd_beat_s[k*W_D +: W_D] = mem_q[rd_bank_q][rd_col_q][k*W_D +: W_D];
      end
    end
  end

  // Full flags: write side sets, read side clears; they never hit the same bank
  // in one cycle because writes never target a bank that is still full.
  always_comb begin
    full_d            = full_q;
    full_d[wr_bank_q] = full_d[wr_bank_q] | wr_last_s;
    full_d[rd_bank_q] = full_d[rd_bank_q] & ~rd_last_s;
  end

  // Row storage into the current write bank.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_bank_q][wr_row_q] <= in_data;
    end
  end

  // Control state and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_col_q    <= '0;
      full_q      <= 2'b00;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      full_q <= full_d;

      if (wr_en_s) begin
        // N is a power of two, so the row counter wraps on its own.
        wr_row_q <= wr_row_q + LOG_N'(1);
        if (wr_row_q == '0) begin
          mode_q[wr_bank_q] <= mode_tr;
        end
        if (wr_last_s) begin
          wr_bank_q <= ~wr_bank_q;
        end
      end

      if (rd_en_s) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rd_beat_s;
        out_first_q <= (rd_col_q == '0);
        out_last_q  <= (rd_col_q == LOG_N'(N - 1));
        rd_col_q    <= rd_col_q + LOG_N'(1);
        if (rd_last_s) begin
          rd_bank_q <= ~rd_bank_q;
        end
      end else if (out_ready) begin
        // Beat taken and nothing ready to replace it.
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dct_transpose_pingpong.md
Name: dct_transpose_pingpong

Overview:
- Parametrised row-to-column transpose buffer placed between the 1-D row DCT stage and the 1-D column DCT stage of the 2-D DCT pipeline.
- Accepts one N-element row per handshake and emits one N-element column per handshake.
- Two N×N banks in ping-pong so one block fills while the other drains, sustaining one row in and one column out per cycle.
- Adds valid/ready flow control, a per-block transpose/pass-through mode, and block framing flags.

Parameters:
- W_D, 26, width of one element (signed, stored and returned unmodified)
- N, 8, block dimension (rows per block = columns per block = elements per beat); power of two, 2..16
- LOG_N, 3, log2(N); counter width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data holds a valid row
- in_ready  output  1  buffer can accept a row this cycle
- in_data  input  N*W_D  row; element k at bits [k*W_D +: W_D]
- mode_tr  input  1  1 = transpose, 0 = pass-through (rows out in input order); sampled with row 0 of each block
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  downstream accepts the beat
- out_data  output  N*W_D  column c: element k = row k, column c of the block (pass-through: row c unchanged)
- out_first  output  1  beat is column/row 0 of a block
- out_last  output  1  beat is column/row N-1 of a block

Behaviour:
- Reset (rst=1 at an edge), regardless of state or in-progress block:
  - in_ready=1 after the edge; out_valid, out_first, out_last = 0; out_data = 0.
  - Write bank=0, read bank=0, row and column counters=0, both bank-full flags=0.
  - Bank memory contents are not cleared; partially written or partially read blocks are discarded.
- Write side:
  - Accept = in_valid & in_ready. in_ready = !full[wr_bank].
  - On accept, the row is stored at wr_row of wr_bank and wr_row increments.
  - On row 0 accept, mode_tr is latched into mode[wr_bank].
  - On accept with wr_row==N-1: full[wr_bank] is set, wr_row wraps to 0, wr_bank toggles.
- Read side (registered output stage):
  - The output register loads when full[rd_bank] & (!out_valid | out_ready).
  - Data loaded: column rd_col of rd_bank (transpose), or row rd_col (pass-through).
  - out_first = (rd_col==0); out_last = (rd_col==N-1).
  - rd_col increments on each load. On the load with rd_col==N-1, full[rd_bank] clears, rd_col wraps to 0, and rd_bank toggles.
  - If out_ready=1 and no full bank is available, out_valid drops to 0 at the edge.
  - out_data holds its value while out_valid & !out_ready.
- Latency:
  - Last-row accept at edge E sets the full flag.
  - Column 0 is loaded at edge E+1, so out_valid is high from E+1.
  - With out_ready held high, columns 0..N-1 appear on consecutive cycles.
- Throughput:
  - Continuous in_valid and out_ready sustain 1 row/cycle in and 1 column/cycle out with no bubbles.
  - in_ready never drops in this condition, because the drain bank frees at the edge its column N-1 is loaded.
- Simultaneous events:
  - Setting full[x] (write side) and clearing full[y] (read side) at the same edge is legal for x≠y.
  - x==y cannot occur.
  - Writes never target the bank being read.
- Backpressure:
  - With both banks full, in_ready=0 and input is stalled losslessly.
  - in_ready returns the cycle after the edge that clears the read bank's full flag.
- Arithmetic: none; data is bit-exact, and sign is carried only as stored bits.
- mode_tr changes mid-block are ignored until the next block's row 0.

Test Plan:
- Single block, N=8, W_D=26: element(r,c)=r*16+c, 8 rows back-to-back, out_ready=1, mode_tr=1.
  - out_valid rises the edge after the last-row accept.
  - Beat c carries element k = k*16+c.
  - out_first on beat 0, out_last on beat 7.
- Streaming: 4 consecutive blocks (block b adds b*256), in_valid and out_ready held 1.
  - in_ready stays 1 throughout.
  - 32 output beats on consecutive cycles, correctly transposed, block order preserved.
- Backpressure: 3 blocks offered with out_ready=0.
  - in_ready drops after the 16th row accept.
  - out_data is stable while stalled.
  - Toggling out_ready 1/0 thereafter yields all 24 columns exactly once, in order.
- Mode: block 0 with mode_tr=0 (switched to 1 at row 3), block 1 with mode_tr=1.
  - Block 0 is output as rows 0..7 unchanged.
  - Block 1 is output transposed.
- Signed extremes: elements alternating -2^25 and 2^25-1.
  - Output bits are identical to input bits at their transposed positions.
- Reset mid-operation: rst=1 for one cycle after 5 rows of block 1 while block 0 is half drained.
  - out_valid=0 and in_ready=1 after the edge.
  - A fresh block then transposes correctly with no stale beats emitted.
